// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts bitstream words on a valid/ready stream and
// serializes them LSB first onto a configuration chain head, issuing one
// shift enable per bit for exactly CHAIN_LEN bits, then pulses done.
// Optional tail readback collector: define CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 40,
  parameter int unsigned WORD_W    = 32
) (
  input  logic                           prog_clk,
  input  logic                           pReset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic                           ccff_head,
  output logic                           ccff_shift_en,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bits_left
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0]              rb_data,
  output logic                           rb_valid
`endif
);

  localparam int unsigned BW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned WCW    = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic [WORD_W-1:0] buf_q, buf_nxt;
  logic              buf_vld_q, buf_vld_nxt;
  logic [IW-1:0]     idx_q, idx_nxt;
  logic [WCW-1:0]    words_q, words_nxt;
  logic [BW-1:0]     bits_nxt;
  logic              head_nxt, shift_nxt, busy_nxt, done_nxt;
  logic              last_bit;

  // Next-state, datapath and output decode; wr_ready is a combinational handshake.
  always_comb begin
    state_nxt   = state_q;
    buf_nxt     = buf_q;
    buf_vld_nxt = buf_vld_q;
    idx_nxt     = idx_q;
    words_nxt   = words_q;
    bits_nxt    = bits_left;
    head_nxt    = ccff_head;
    shift_nxt   = 1'b0;
    done_nxt    = 1'b0;
    wr_ready    = 1'b0;
    last_bit    = buf_vld_q && (idx_q == IW'(WORD_W - 1));

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = LOAD;
          bits_nxt    = BW'(CHAIN_LEN);
          buf_vld_nxt = 1'b0;
          idx_nxt     = '0;
          words_nxt   = '0;
        end
      end
      LOAD: begin
        // A word may be taken while the buffered word issues its last bit.
        wr_ready = !abort && (!buf_vld_q || last_bit) && (words_q < WCW'(NWORDS));
        if (abort) begin
          state_nxt   = IDLE;
          bits_nxt    = '0;
          buf_vld_nxt = 1'b0;
        end else begin
          if (buf_vld_q) begin
            head_nxt  = buf_q[idx_q];
            shift_nxt = 1'b1;
            bits_nxt  = bits_left - BW'(1);
            idx_nxt   = idx_q + IW'(1);
            if (last_bit) begin
              buf_vld_nxt = 1'b0;
            end
            // Final chain bit: leftover bits of the last word are dropped.
            if (bits_left == BW'(1)) begin
              state_nxt   = DONE;
              buf_vld_nxt = 1'b0;
            end
          end
          if (wr_valid && wr_ready) begin
            buf_nxt     = wr_data;
            buf_vld_nxt = 1'b1;
            idx_nxt     = '0;
            words_nxt   = words_q + WCW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done_nxt  = !abort;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == LOAD);
  end

  // State, buffer and registered outputs.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      buf_vld_q     <= 1'b0;
      idx_q         <= '0;
      words_q       <= '0;
      bits_left     <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      buf_q         <= buf_nxt;
      buf_vld_q     <= buf_vld_nxt;
      idx_q         <= idx_nxt;
      words_q       <= words_nxt;
      bits_left     <= bits_nxt;
      ccff_head     <= head_nxt;
      ccff_shift_en <= shift_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] col_q, col_nxt, rb_data_nxt;
  logic [IW-1:0]     cnt_q, cnt_nxt;
  logic              rb_valid_nxt;

  // Collect the tail bit on every chain shift; flush full words and the final partial word.
  always_comb begin
    col_nxt      = col_q;
    cnt_nxt      = cnt_q;
    rb_data_nxt  = rb_data;
    rb_valid_nxt = 1'b0;
    if (abort || (state_q == IDLE && start)) begin
      col_nxt = '0;
      cnt_nxt = '0;
    end else if (ccff_shift_en) begin
      col_nxt[cnt_q] = ccff_tail;
      if ((cnt_q == IW'(WORD_W - 1)) || (state_q == DONE)) begin
        rb_valid_nxt = 1'b1;
        rb_data_nxt  = col_nxt;
        col_nxt      = '0;
        cnt_nxt      = '0;
      end else begin
        cnt_nxt = cnt_q + IW'(1);
      end
    end
  end

  // Readback collector registers.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      col_q    <= '0;
      cnt_q    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      col_q    <= col_nxt;
      cnt_q    <= cnt_nxt;
      rb_data  <= rb_data_nxt;
      rb_valid <= rb_valid_nxt;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
